// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor: one decade per clock, LSD first,
// decimal carry/borrow chained between digits, one-cycle done pulse at the end.
module bcd_addsub_serial #(
  parameter int DIGITS = 4,
  parameter int IDXW   = $clog2(DIGITS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  sub,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [W-1:0]    a_q, b_q, result_q;
  logic            sub_q, carry_q, cout_q, err_q;
  logic [IDXW-1:0] idx_q;

  logic            last_digit;
  logic            in_err;
  logic [3:0]      b_dig;
  logic [3:0]      digit;
  logic [4:0]      sum;
  logic            carry_nx;
  logic [W+3:0]    res_ext;

  assign last_digit = (idx_q == IDXW'(DIGITS - 1));

  // Any non-decimal nibble in either operand poisons the whole operation.
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) in_err = 1'b1;
    end
  end

  // Operands shift right each RUN cycle, so the active digit is always [3:0];
  // result digits enter from the top and reach their place after DIGITS shifts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    carry_nx = 1'b0;
    b_dig    = sub_q ? (4'd9 - b_q[3:0]) : b_q[3:0];
    sum      = 5'(a_q[3:0]) + 5'(b_dig) + 5'(carry_q);
    digit    = sum[3:0];
    if (sum > 5'd9) begin
      digit    = 4'(sum - 5'd10);
      carry_nx = 1'b1;
    end
    res_ext = {digit, result_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start)      state_nx = RUN;
      RUN:     if (last_digit) state_nx = DONE;
      DONE:                    state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            sub_q   <= sub;
            carry_q <= cin;
            idx_q   <= '0;
            err_q   <= in_err;
          end
        end
        RUN: begin
          a_q      <= a_q >> 4;
          b_q      <= b_q >> 4;
          carry_q  <= carry_nx;
          result_q <= res_ext[W+3:4];
          if (last_digit) begin
            cout_q <= carry_nx & ~err_q;
            if (err_q) result_q <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Scoreboard bench for bcd_addsub_serial: a 4-digit and a 1-digit instance,
// expectations from an integer-arithmetic model, compared when done pulses.
module tb_bcd_addsub_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, start1, sub, cin;
  logic [15:0] a4, b4;
  logic [3:0]  a1, b1;

  logic        busy4, done4, cout4, err4;
  logic [15:0] result4;
  logic        busy1, done1, cout1, err1;
  logic [3:0]  result1;

  always #5 clk = ~clk;

  bcd_addsub_serial #(.DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .sub(sub), .cin(cin),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4), .err(err4)
  );

  bcd_addsub_serial #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .sub(sub), .cin(cin),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .err(err1)
  );

  typedef struct {
    logic [15:0] r;
    logic        co;
    logic        er;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t m4, m1;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Decimal reference: convert to integers, add (or add 9's complement), split.
  function automatic exp_t model(input int d, input logic [15:0] a, input logic [15:0] b,
                                 input logic s, input logic c);
    exp_t       e;
    longint     av = 0, bv = 0, pw = 1, tot;
    logic [3:0] da, db;
    logic       er = 1'b0;
    for (int i = 0; i < d; i++) begin
      da = a[4*i +: 4];
      db = b[4*i +: 4];
      if (da > 4'd9 || db > 4'd9) er = 1'b1;
      av += longint'(da) * pw;
      bv += longint'(db) * pw;
      pw *= 10;
    end
    tot  = av + (s ? (pw - 1 - bv) : bv) + longint'(c);
    e.co = (tot >= pw);
    tot  = tot % pw;
    e.r  = '0;
    for (int i = 0; i < d; i++) begin
      e.r[4*i +: 4] = 4'(tot % 10);
      tot = tot / 10;
    end
    e.er = er;
    if (er) begin
      e.r  = '0;
      e.co = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) check("spurious_done4", 32'(done4), 32'd0);
      else begin
        m4 = q4.pop_front();
        check("result4", 32'(result4), 32'(m4.r));
        check("cout4", 32'(cout4), 32'(m4.co));
        check("err4", 32'(err4), 32'(m4.er));
      end
    end
    if (done1 === 1'b1) begin
      if (q1.size() == 0) check("spurious_done1", 32'(done1), 32'd0);
      else begin
        m1 = q1.pop_front();
        check("result1", 32'(result1), 32'(m1.r));
        check("cout1", 32'(cout1), 32'(m1.co));
        check("err1", 32'(err1), 32'(m1.er));
      end
    end
  end

  // One operation on the w-digit instance; optionally pulses a second start
  // with other operands mid-RUN, which must be ignored.
  task automatic op(input int w, input logic [15:0] a, input logic [15:0] b,
                    input logic s, input logic c, input logic inject);
    exp_t e;
    int   lat = -1;
    int   bad = 0;
    logic [15:0] res_now;
    e = model(w, a, b, s, c);
    @(negedge clk);
    sub = s;
    cin = c;
    if (w == 4) begin
      a4 = a; b4 = b; start4 = 1'b1; q4.push_back(e);
    end else begin
      a1 = a[3:0]; b1 = b[3:0]; start1 = 1'b1; q1.push_back(e);
    end
    @(posedge clk);
    for (int i = 1; i <= w + 4; i++) begin
      @(negedge clk);
      if (i == 1) begin start4 = 1'b0; start1 = 1'b0; end
      if (inject && i == 2) begin
        start4 = 1'b1; a4 = 16'h4321; b4 = 16'h1111; sub = ~s; cin = ~c;
      end
      if (inject && i == 3) start4 = 1'b0;
      if ((w == 4) ? done4 : done1) begin
        lat = i - 1;
        break;
      end
      if (!((w == 4) ? busy4 : busy1)) bad++;
    end
    check("latency", 32'(lat), 32'(w));
    check("busy_run", 32'(bad), 32'd0);
    @(negedge clk);
    res_now = (w == 4) ? result4 : {12'h000, result1};
    check("done_pulse_width", 32'((w == 4) ? done4 : done1), 32'd0);
    check("busy_after_done", 32'((w == 4) ? busy4 : busy1), 32'd0);
    check("result_hold", 32'(res_now), 32'(e.r));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    int          dones;
    rst = 1'b1;
    start4 = 1'b1; start1 = 1'b1;
    a4 = 16'h1111; b4 = 16'h2222; a1 = 4'd1; b1 = 4'd2; sub = 1'b0; cin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy4", 32'(busy4), 32'd0);
    check("rst_done4", 32'(done4), 32'd0);
    check("rst_result4", 32'(result4), 32'd0);
    check("rst_cout4", 32'(cout4), 32'd0);
    check("rst_err4", 32'(err4), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    start4 = 1'b0; start1 = 1'b0;
    rst = 1'b0;

    op(4, 16'h0007, 16'h0003, 1'b1, 1'b1, 1'b0);
    op(4, 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0);
    op(4, 16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0);
    op(4, 16'h0003, 16'h0007, 1'b1, 1'b1, 1'b0);
    op(4, 16'h0009, 16'h0007, 1'b1, 1'b1, 1'b0);
    op(1, 16'h0009, 16'h0009, 1'b0, 1'b0, 1'b0);
    op(1, 16'h0008, 16'h0005, 1'b0, 1'b0, 1'b0);
    op(1, 16'h0002, 16'h0007, 1'b1, 1'b1, 1'b0);
    op(4, 16'h12A4, 16'h0001, 1'b0, 1'b0, 1'b0);
    op(4, 16'h0042, 16'h0011, 1'b0, 1'b0, 1'b0);
    op(4, 16'h5000, 16'h2500, 1'b1, 1'b1, 1'b1);

    // Reset two cycles into RUN: outputs clear at once, no done follows.
    @(negedge clk);
    a4 = 16'h1111; b4 = 16'h2222; sub = 1'b0; cin = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy4), 32'd0);
    check("midrst_done", 32'(done4), 32'd0);
    check("midrst_result", 32'(result4), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    check("midrst_idle", 32'(busy4), 32'd0);

    op(4, 16'h4567, 16'h1234, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      ra = '0; rb = '0;
      for (int d = 0; d < 4; d++) begin
        ra[4*d +: 4] = 4'($urandom_range(0, 9));
        rb[4*d +: 4] = 4'($urandom_range(0, 9));
      end
      op(4, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q4.size() + q1.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
